// File: rtl/cmac_axis_rx_pkt_chk.sv
// RX packet checker for the CMAC AXI-Stream user interface: validates incrementing-byte
// payload, tkeep shape, length and MAC error per packet, and counts results per test run.
module cmac_axis_rx_pkt_chk #(
  parameter int unsigned PKT_NUM  = 1000,
  parameter int unsigned PKT_SIZE = 8192
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stat_rx_aligned,
  input  logic         restart,
  input  logic         rx_axis_tvalid,
  input  logic [511:0] rx_axis_tdata,
  input  logic [63:0]  rx_axis_tkeep,
  input  logic         rx_axis_tlast,
  input  logic         rx_axis_tuser,
  output logic         rx_aligned_led,
  output logic         rx_busy_led,
  output logic         rx_done_led,
  output logic         rx_fail_led,
  output logic [15:0]  pkt_good_cnt,
  output logic [15:0]  pkt_err_cnt,
  output logic [31:0]  byte_cnt
);

  localparam int unsigned KEEP_W = 64;
  localparam int unsigned BEAT_W = 9;
  localparam int unsigned POP_W  = 7;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned TOT_W  = CNT_W + 1;
  localparam int unsigned BYTE_W = 32;
  localparam int unsigned SUM_W  = BYTE_W + 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_ALIGN = 2'd1,
    RECEIVE    = 2'd2,
    DONE       = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [BEAT_W-1:0] beat_cnt;
  logic              err_acc;
  logic [POP_W-1:0]  keep_pop;
  logic              data_err;
  logic              keep_last_ok;
  logic              keep_err;
  logic [LEN_W-1:0]  pkt_len;
  logic              len_err;
  logic              pkt_bad;
  logic              run_full;
  logic [SUM_W-1:0]  byte_sum;
  logic              accept_beat;
  logic              abort_err;
  logic              clear_run;

  // Per-beat payload compare against byte n = n mod 256, plus valid-byte popcount
  always_comb begin
    keep_pop = '0;
    data_err = 1'b0;
    for (int j = 0; j < KEEP_W; j++) begin
      if (rx_axis_tkeep[j]) begin
        keep_pop = keep_pop + POP_W'(1);
        if (rx_axis_tdata[8*j +: 8] != ({beat_cnt[1:0], 6'b0} + 8'(j)))
          data_err = 1'b1;
      end
    end
  end

  // Last beat must be a nonzero LSB-contiguous mask; x & (x+1) == 0 only for 2^k-1
  assign keep_last_ok = (rx_axis_tkeep != '0) &&
                        ((rx_axis_tkeep & (rx_axis_tkeep + KEEP_W'(1))) == '0);
  assign keep_err     = rx_axis_tlast ? !keep_last_ok : (rx_axis_tkeep != '1);
  assign pkt_len      = LEN_W'({beat_cnt, 6'b0}) + LEN_W'(keep_pop);
  assign len_err      = (pkt_len != LEN_W'(PKT_SIZE));
  assign pkt_bad      = err_acc | data_err | keep_err | len_err | rx_axis_tuser;
  assign run_full     = (TOT_W'(pkt_good_cnt) + TOT_W'(pkt_err_cnt)) == TOT_W'(PKT_NUM);
  assign byte_sum     = SUM_W'(byte_cnt) + SUM_W'(keep_pop);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and datapath strobes; restart outranks every other event
  always_comb begin
    state_next  = state;
    accept_beat = 1'b0;
    abort_err   = 1'b0;
    clear_run   = 1'b0;
    if (restart) begin
      state_next = WAIT_ALIGN;
      clear_run  = 1'b1;
    end else begin
      case (state)
        IDLE: state_next = IDLE;
        WAIT_ALIGN: begin
          if (stat_rx_aligned && !rx_axis_tvalid) state_next = RECEIVE;
        end
        RECEIVE: begin
          if (run_full) begin
            state_next = DONE;
          end else if (!stat_rx_aligned) begin
            state_next = WAIT_ALIGN;
            abort_err  = (beat_cnt != '0) || rx_axis_tvalid;
          end else begin
            accept_beat = rx_axis_tvalid;
          end
        end
        DONE: state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_aligned_led <= 1'b0;
      rx_busy_led    <= 1'b0;
      rx_done_led    <= 1'b0;
      rx_fail_led    <= 1'b0;
      pkt_good_cnt   <= '0;
      pkt_err_cnt    <= '0;
      byte_cnt       <= '0;
      beat_cnt       <= '0;
      err_acc        <= 1'b0;
    end else begin
      rx_aligned_led <= stat_rx_aligned;
      rx_busy_led    <= (state_next == RECEIVE);
      rx_done_led    <= (state_next == DONE);
      if (clear_run) begin
        rx_fail_led  <= 1'b0;
        pkt_good_cnt <= '0;
        pkt_err_cnt  <= '0;
        byte_cnt     <= '0;
        beat_cnt     <= '0;
        err_acc      <= 1'b0;
      end else if (abort_err) begin
        pkt_err_cnt <= pkt_err_cnt + CNT_W'(1);
        rx_fail_led <= 1'b1;
        beat_cnt    <= '0;
        err_acc     <= 1'b0;
      end else if (accept_beat) begin
        byte_cnt <= byte_sum[SUM_W-1] ? '1 : byte_sum[BYTE_W-1:0];
        if (rx_axis_tlast) begin
          beat_cnt <= '0;
          err_acc  <= 1'b0;
          if (pkt_bad) begin
            pkt_err_cnt <= pkt_err_cnt + CNT_W'(1);
            rx_fail_led <= 1'b1;
          end else begin
            pkt_good_cnt <= pkt_good_cnt + CNT_W'(1);
          end
        end else begin
          // Saturate so oversize packets cannot wrap back into a valid length
          if (beat_cnt != '1) beat_cnt <= beat_cnt + BEAT_W'(1);
          err_acc <= err_acc | data_err | keep_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_cmac_axis_rx_pkt_chk.sv
// Directed bench for cmac_axis_rx_pkt_chk with PKT_NUM=4, PKT_SIZE=200.
module tb_cmac_axis_rx_pkt_chk;

  logic         clk = 1'b0;
  logic         reset;
  logic         stat_rx_aligned;
  logic         restart;
  logic         rx_axis_tvalid;
  logic [511:0] rx_axis_tdata;
  logic [63:0]  rx_axis_tkeep;
  logic         rx_axis_tlast;
  logic         rx_axis_tuser;
  logic         rx_aligned_led;
  logic         rx_busy_led;
  logic         rx_done_led;
  logic         rx_fail_led;
  logic [15:0]  pkt_good_cnt;
  logic [15:0]  pkt_err_cnt;
  logic [31:0]  byte_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  cmac_axis_rx_pkt_chk #(.PKT_NUM(4), .PKT_SIZE(200)) dut (
    .clk             (clk),
    .reset           (reset),
    .stat_rx_aligned (stat_rx_aligned),
    .restart         (restart),
    .rx_axis_tvalid  (rx_axis_tvalid),
    .rx_axis_tdata   (rx_axis_tdata),
    .rx_axis_tkeep   (rx_axis_tkeep),
    .rx_axis_tlast   (rx_axis_tlast),
    .rx_axis_tuser   (rx_axis_tuser),
    .rx_aligned_led  (rx_aligned_led),
    .rx_busy_led     (rx_busy_led),
    .rx_done_led     (rx_done_led),
    .rx_fail_led     (rx_fail_led),
    .pkt_good_cnt    (pkt_good_cnt),
    .pkt_err_cnt     (pkt_err_cnt),
    .byte_cnt        (byte_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rx_axis_tvalid = 1'b0;
    rx_axis_tdata  = '0;
    rx_axis_tkeep  = '0;
    rx_axis_tlast  = 1'b0;
    rx_axis_tuser  = 1'b0;
  endtask

  // Present one beat of the incrementing pattern for beat index b, optionally corrupting byte bad_j
  task automatic send_beat(input int b, input logic [63:0] k, input bit last,
                           input bit user, input int bad_j);
    logic [511:0] d;
    for (int j = 0; j < 64; j++) d[8*j +: 8] = 8'((64*b + j) % 256);
    if (bad_j >= 0) d[8*bad_j +: 8] = ~d[8*bad_j +: 8];
    rx_axis_tvalid = 1'b1;
    rx_axis_tdata  = d;
    rx_axis_tkeep  = k;
    rx_axis_tlast  = last;
    rx_axis_tuser  = user;
    tick();
  endtask

  task automatic send_pkt(input int nbytes, input bit user, input int bad_byte,
                          input int bad_keep_beat);
    int nb;
    nb = (nbytes + 63) / 64;
    for (int b = 0; b < nb; b++) begin
      int rem;
      int bj;
      logic [63:0] k;
      rem = nbytes - 64*b;
      k = (rem >= 64) ? '1 : ((64'd1 << rem) - 64'd1);
      if (b == bad_keep_beat) k = 64'h7FFF_FFFF_FFFF_FFFF;
      bj = (bad_byte >= 64*b && bad_byte < 64*b + 64) ? bad_byte - 64*b : -1;
      send_beat(b, k, (b == nb-1), user && (b == nb-1), bj);
    end
    idle_in();
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    stat_rx_aligned = 1'b1;
    restart = 1'b0;
    idle_in();
    tick();
    tick();
    check("rst_aligned_led", 32'(rx_aligned_led), 0);
    check("rst_busy", 32'(rx_busy_led), 0);
    check("rst_good", 32'(pkt_good_cnt), 0);
    check("rst_bytes", byte_cnt, 0);
    reset = 1'b0;
    tick();
    check("aligned_led", 32'(rx_aligned_led), 1);
    send_pkt(200, 0, -1, -1);
    check("idle_ignore_good", 32'(pkt_good_cnt), 0);
    check("idle_ignore_bytes", byte_cnt, 0);
    check("idle_stays", 32'(rx_busy_led), 0);

    // Four clean packets
    do_restart();
    tick();
    check("recv_busy", 32'(rx_busy_led), 1);
    for (int p = 0; p < 4; p++) send_pkt(200, 0, -1, -1);
    check("run1_good", 32'(pkt_good_cnt), 4);
    check("run1_err", 32'(pkt_err_cnt), 0);
    check("run1_bytes", byte_cnt, 800);
    tick();
    check("run1_done", 32'(rx_done_led), 1);
    check("run1_busy", 32'(rx_busy_led), 0);
    check("run1_fail", 32'(rx_fail_led), 0);
    send_pkt(200, 0, -1, -1);
    check("done_ignore_bytes", byte_cnt, 800);

    // Restart from DONE, then corrupt byte 70 of packet 2
    do_restart();
    check("rs_done_clr", 32'(rx_done_led), 0);
    check("rs_good_clr", 32'(pkt_good_cnt), 0);
    check("rs_bytes_clr", byte_cnt, 0);
    tick();
    send_pkt(200, 0, -1, -1);
    check("run2_fail_pre", 32'(rx_fail_led), 0);
    send_pkt(200, 0, 70, -1);
    check("run2_err", 32'(pkt_err_cnt), 1);
    check("run2_fail", 32'(rx_fail_led), 1);
    send_pkt(200, 0, -1, -1);
    send_pkt(200, 0, -1, -1);
    check("run2_good", 32'(pkt_good_cnt), 3);
    tick();
    check("run2_done", 32'(rx_done_led), 1);

    // Short packet, tuser, bad middle tkeep
    do_restart();
    tick();
    send_pkt(199, 0, -1, -1);
    check("len_err", 32'(pkt_err_cnt), 1);
    send_pkt(200, 1, -1, -1);
    check("tuser_err", 32'(pkt_err_cnt), 2);
    send_pkt(200, 0, -1, 1);
    check("keep_err", 32'(pkt_err_cnt), 3);
    check("run3_good", 32'(pkt_good_cnt), 0);
    check("run3_bytes", byte_cnt, 598);

    // Alignment lost on beat 2
    do_restart();
    tick();
    send_beat(0, '1, 0, 0, -1);
    send_beat(1, '1, 0, 0, -1);
    stat_rx_aligned = 1'b0;
    send_beat(2, '1, 0, 0, -1);
    check("align_err", 32'(pkt_err_cnt), 1);
    check("align_fail", 32'(rx_fail_led), 1);
    check("align_wait", 32'(rx_busy_led), 0);
    check("align_bytes", byte_cnt, 128);
    send_beat(3, 64'hFF, 1, 0, -1);
    stat_rx_aligned = 1'b1;
    send_beat(0, '1, 0, 0, -1);
    check("realign_tvalid_hold", 32'(rx_busy_led), 0);
    idle_in();
    tick();
    check("realign_recv", 32'(rx_busy_led), 1);
    send_pkt(200, 0, -1, -1);
    check("realign_good", 32'(pkt_good_cnt), 1);
    check("realign_err_kept", 32'(pkt_err_cnt), 1);

    // Restart coincident with tlast
    send_beat(0, '1, 0, 0, -1);
    send_beat(1, '1, 0, 0, -1);
    send_beat(2, '1, 0, 0, -1);
    restart = 1'b1;
    send_beat(3, 64'hFF, 1, 0, -1);
    restart = 1'b0;
    idle_in();
    check("rs_tlast_good", 32'(pkt_good_cnt), 0);
    check("rs_tlast_err", 32'(pkt_err_cnt), 0);
    check("rs_tlast_bytes", byte_cnt, 0);
    check("rs_tlast_fail", 32'(rx_fail_led), 0);

    // Reset mid-packet
    tick();
    send_pkt(199, 0, -1, -1);
    check("pre_rst_fail", 32'(rx_fail_led), 1);
    send_beat(0, '1, 0, 0, -1);
    send_beat(1, '1, 0, 0, -1);
    reset = 1'b1;
    send_beat(2, '1, 0, 0, -1);
    idle_in();
    check("mid_rst_aligned_led", 32'(rx_aligned_led), 0);
    check("mid_rst_busy", 32'(rx_busy_led), 0);
    check("mid_rst_fail", 32'(rx_fail_led), 0);
    check("mid_rst_err", 32'(pkt_err_cnt), 0);
    check("mid_rst_bytes", byte_cnt, 0);
    reset = 1'b0;
    tick();
    send_pkt(200, 0, -1, -1);
    check("post_rst_idle", 32'(rx_busy_led), 0);
    check("post_rst_good", 32'(pkt_good_cnt), 0);
    check("post_rst_bytes", byte_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
